// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned MAC_CNT_W = 3;
  localparam int unsigned REG_W     = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MAC_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the sources of ID.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic             i_mem_read,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_uses_rt,
  output logic             o_load_use
);

  logic w_rs_match;
  logic w_rt_match;
  logic w_dest_live;

  // A load into $zero never produces a value worth waiting for.
  assign w_dest_live = (i_ex_rt != REG_ZERO);
  assign w_rs_match  = (i_ex_rt == i_id_rs);
  assign w_rt_match  = i_uses_rt & (i_ex_rt == i_id_rt);
  assign o_load_use  = i_mem_read & w_dest_live & (w_rs_match | w_rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush control for load-use and HI/LO multiply-accumulate hazards.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MAC_CYCLES = 3  // legal range 2..7
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 ID_EX_MemRead,
  input  logic [REG_W-1:0]     ID_EX_Rt,
  input  logic [REG_W-1:0]     IF_ID_Rs,
  input  logic [REG_W-1:0]     IF_ID_Rt,
  input  logic                 ID_UsesRt,
  input  logic                 ID_Madd,
  input  logic                 ID_Msub,
  input  logic                 ID_HiLoRead,
  input  logic                 BranchTaken,
  output logic                 PCWrite,
  output logic                 IFIDWrite,
  output logic                 IFIDFlush,
  output logic                 IDEXBubble,
  output logic                 MacBusy,
  output logic                 MacAbort,
  output logic [MAC_CNT_W-1:0] MacCount
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]          StallCount
`endif
);

  localparam logic [MAC_CNT_W-1:0] MAC_INIT = MAC_CNT_W'(MAC_CYCLES);

  hz_state_t              r_state;
  hz_state_t              w_next_state;
  logic [MAC_CNT_W-1:0]   r_count;
  logic [MAC_CNT_W-1:0]   w_next_count;
  logic                   w_load_use;
  logic                   w_mac_hazard;
  logic                   w_stall;
  logic                   w_mac_issue;
  logic                   w_mac_abort;

  load_use_detect u_load_use_detect (
    .i_mem_read (ID_EX_MemRead),
    .i_ex_rt    (ID_EX_Rt),
    .i_id_rs    (IF_ID_Rs),
    .i_id_rt    (IF_ID_Rt),
    .i_uses_rt  (ID_UsesRt),
    .o_load_use (w_load_use)
  );

  // Any HI/LO user in ID waits while a MAC is in flight; a taken branch overrides every stall.
  assign w_mac_hazard = (r_state == MAC_WAIT) & (ID_Madd | ID_Msub | ID_HiLoRead);
  assign w_stall      = (w_load_use | w_mac_hazard) & ~BranchTaken;
  assign w_mac_issue  = (ID_Madd | ID_Msub) & ~w_stall & ~BranchTaken;

  // State and counter advance with the pipeline registers on the falling edge.
  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= RUN;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_mac_abort  = 1'b0;
    case (r_state)
      RUN: begin
        w_next_count = '0;
        if (w_mac_issue) begin
          w_next_state = MAC_WAIT;
          w_next_count = MAC_INIT;
        end
      end
      MAC_WAIT: begin
        // Only a MAC still at its full count is younger than the branch and gets squashed.
        if (BranchTaken && (r_count == MAC_INIT)) begin
          w_mac_abort  = 1'b1;
          w_next_state = RUN;
          w_next_count = '0;
        end else if (r_count <= MAC_CNT_W'(1)) begin
          w_next_state = RUN;
          w_next_count = '0;
        end else begin
          w_next_count = r_count - MAC_CNT_W'(1);
        end
      end
      default: begin
        w_next_state = RUN;
        w_next_count = '0;
      end
    endcase
  end

  // Reset forces the safe pipeline controls regardless of the clock.
  assign PCWrite    = Rst_n & ~w_stall;
  assign IFIDWrite  = Rst_n & ~w_stall;
  assign IFIDFlush  = ~Rst_n | BranchTaken;
  assign IDEXBubble = ~Rst_n | w_stall | BranchTaken;
  assign MacBusy    = Rst_n & (r_state == MAC_WAIT);
  assign MacAbort   = Rst_n & w_mac_abort;
  assign MacCount   = r_count;

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_count;

  // Saturating count of stalled cycles.
  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign StallCount = r_stall_count;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios then randomized traffic.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MC = 3;

  logic       Clk = 1'b1;
  logic       Rst_n = 1'b0;
  logic       ID_EX_MemRead = 1'b0;
  logic [4:0] ID_EX_Rt = '0;
  logic [4:0] IF_ID_Rs = '0;
  logic [4:0] IF_ID_Rt = '0;
  logic       ID_UsesRt = 1'b0;
  logic       ID_Madd = 1'b0;
  logic       ID_Msub = 1'b0;
  logic       ID_HiLoRead = 1'b0;
  logic       BranchTaken = 1'b0;
  logic       PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MacBusy, MacAbort;
  logic [2:0] MacCount;
  logic [15:0] sc_w;

  typedef struct packed {
    logic       memread;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesrt;
    logic       madd;
    logic       msub;
    logic       hilo;
    logic       bt;
  } stim_t;

  typedef struct packed {
    logic        pcw;
    logic        ifidw;
    logic        flush;
    logic        bubble;
    logic        busy;
    logic        abort;
    logic [2:0]  cnt;
    logic [15:0] sc;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rem     = 0;   // MAC cycles still owed by the HI/LO unit, 0 when idle
  int   stalls  = 0;
  int   mon_cyc = 0;

  pipeline_hazard_ctrl #(.MAC_CYCLES(MC)) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .ID_EX_MemRead (ID_EX_MemRead),
    .ID_EX_Rt      (ID_EX_Rt),
    .IF_ID_Rs      (IF_ID_Rs),
    .IF_ID_Rt      (IF_ID_Rt),
    .ID_UsesRt     (ID_UsesRt),
    .ID_Madd       (ID_Madd),
    .ID_Msub       (ID_Msub),
    .ID_HiLoRead   (ID_HiLoRead),
    .BranchTaken   (BranchTaken),
    .PCWrite       (PCWrite),
    .IFIDWrite     (IFIDWrite),
    .IFIDFlush     (IFIDFlush),
    .IDEXBubble    (IDEXBubble),
    .MacBusy       (MacBusy),
    .MacAbort      (MacAbort),
    .MacCount      (MacCount)
`ifdef HAZARD_STATS_EN
    ,
    .StallCount    (sc_w)
`endif
  );

`ifndef HAZARD_STATS_EN
  assign sc_w = 16'd0;
`endif

  always #5 Clk = ~Clk;

  function automatic stim_t mk(input logic mr, input int ert, input int rs, input int rt,
                               input logic ur, input logic ma, input logic ms,
                               input logic hl, input logic bt);
    stim_t s;
    s.memread = mr;
    s.ex_rt   = 5'(ert);
    s.rs      = 5'(rs);
    s.rt      = 5'(rt);
    s.usesrt  = ur;
    s.madd    = ma;
    s.msub    = ms;
    s.hilo    = hl;
    s.bt      = bt;
    return s;
  endfunction

  // Reference model: hazard rules evaluated on the current MAC debt, then the debt is advanced.
  task automatic model(input stim_t s, input logic rst, output obs_t e);
    bit lu, busy, mh, stall, abort;
    if (!rst) begin
      e = '{pcw: 1'b0, ifidw: 1'b0, flush: 1'b1, bubble: 1'b1, busy: 1'b0, abort: 1'b0,
            cnt: 3'd0, sc: 16'd0};
      rem    = 0;
      stalls = 0;
      return;
    end
    lu    = s.memread && (s.ex_rt != 0) && ((s.ex_rt == s.rs) || (s.usesrt && s.ex_rt == s.rt));
    busy  = (rem > 0);
    mh    = busy && (s.madd || s.msub || s.hilo);
    stall = (lu || mh) && !s.bt;
    abort = busy && s.bt && (rem == MC);
    e.pcw    = !stall;
    e.ifidw  = !stall;
    e.flush  = s.bt;
    e.bubble = stall || s.bt;
    e.busy   = busy;
    e.abort  = abort;
    e.cnt    = 3'(rem);
`ifdef HAZARD_STATS_EN
    e.sc     = 16'(stalls);
`else
    e.sc     = 16'd0;
`endif
    if (!busy)      rem = ((s.madd || s.msub) && !stall && !s.bt) ? MC : 0;
    else if (abort) rem = 0;
    else            rem = rem - 1;
    if (stall && stalls < 65535) stalls = stalls + 1;
  endtask

  task automatic step(input stim_t s, input logic rst);
    obs_t e;
    @(negedge Clk);
    #1;
    Rst_n         = rst;
    ID_EX_MemRead = s.memread;
    ID_EX_Rt      = s.ex_rt;
    IF_ID_Rs      = s.rs;
    IF_ID_Rt      = s.rt;
    ID_UsesRt     = s.usesrt;
    ID_Madd       = s.madd;
    ID_Msub       = s.msub;
    ID_HiLoRead   = s.hilo;
    BranchTaken   = s.bt;
    model(s, rst, e);
    exp_q.push_back(e);
  endtask

  // Asserts reset mid-cycle and checks that the outputs react without waiting for a clock edge.
  task automatic async_reset_check(input string tag);
    @(posedge Clk);
    #2;
    Rst_n  = 1'b0;
    rem    = 0;
    stalls = 0;
    #1;
    n_tests++;
    if (MacBusy !== 1'b0 || MacAbort !== 1'b0 || PCWrite !== 1'b0 || IFIDFlush !== 1'b1 ||
        IDEXBubble !== 1'b1 || MacCount !== 3'd0 || sc_w !== 16'd0) begin
      n_fail++;
      $display("FAIL %s async reset: got busy=%b abort=%b pcw=%b flush=%b bubble=%b cnt=%0d sc=%0d, expected 0 0 0 1 1 0 0",
               tag, MacBusy, MacAbort, PCWrite, IFIDFlush, IDEXBubble, MacCount, sc_w);
    end
  endtask

  // Monitor: compare at the rising edge, half a cycle away from the falling active edge.
  always @(posedge Clk) begin : monitor
    obs_t e;
    obs_t a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MacBusy, MacAbort, MacCount, sc_w};
      n_tests++;
      mon_cyc++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle%0d outputs: got pcw,ifidw,flush,bubble,busy,abort=%b%b%b%b%b%b cnt=%0d sc=%0d, expected %b%b%b%b%b%b cnt=%0d sc=%0d",
                 mon_cyc, a.pcw, a.ifidw, a.flush, a.bubble, a.busy, a.abort, a.cnt, a.sc,
                 e.pcw, e.ifidw, e.flush, e.bubble, e.busy, e.abort, e.cnt, e.sc);
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    stim_t nop;
    stim_t s;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    step(nop, 1'b0);
    step(mk(1, 8, 8, 0, 0, 0, 0, 0, 0), 1'b0);
    // Load-use stall for one cycle, then the load has left EX.
    step(mk(1, 8, 8, 0, 0, 0, 0, 0, 0), 1'b1);
    step(mk(0, 8, 8, 0, 0, 0, 0, 0, 0), 1'b1);
    step(mk(1, 8, 9, 8, 0, 0, 0, 0, 0), 1'b1);
    step(mk(1, 8, 9, 8, 1, 0, 0, 0, 0), 1'b1);
    step(mk(1, 0, 0, 0, 1, 0, 0, 0, 0), 1'b1);
    // MAC then mflo waits through counts 3,2,1 and issues from RUN.
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    repeat (4) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1);
    // Branch in the first MAC_WAIT cycle aborts the MAC.
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1);
    step(nop, 1'b1);
    // Branch at count 2 lets the MAC complete.
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b1);
    step(nop, 1'b1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1);
    step(nop, 1'b1);
    step(nop, 1'b1);
    // madd arriving on the last MAC cycle stalls once, then issues.
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    step(nop, 1'b1);
    step(nop, 1'b1);
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    repeat (4) step(nop, 1'b1);
    // Taken branch beats a load-use hazard; simultaneous load-use and MAC hazard.
    step(mk(1, 5, 5, 0, 0, 0, 0, 0, 1), 1'b1);
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    step(mk(1, 6, 6, 0, 0, 0, 0, 1, 0), 1'b1);
    step(nop, 1'b1);
    step(nop, 1'b1);
    // Reset while MacCount is 2.
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    step(nop, 1'b1);
    step(nop, 1'b1);
    async_reset_check("mid_mac");
    step(nop, 1'b0);
    step(nop, 1'b1);
    step(nop, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      s.memread = ($urandom_range(0, 2) == 0);
      s.ex_rt   = 5'($urandom_range(0, 3));
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.usesrt  = 1'($urandom_range(0, 1));
      s.madd    = ($urandom_range(0, 5) == 0);
      s.msub    = ($urandom_range(0, 7) == 0);
      s.hilo    = ($urandom_range(0, 4) == 0);
      s.bt      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 249) == 0) begin
        async_reset_check("random");
        step(s, 1'b0);
      end else begin
        step(s, 1'b1);
      end
    end

`ifdef HAZARD_STATS_EN
    async_reset_check("stats_clear");
    step(nop, 1'b0);
    for (int i = 0; i < 65540; i++) step(mk(1, 8, 8, 0, 0, 0, 0, 0, 0), 1'b1);
    step(nop, 1'b1);
    step(nop, 1'b1);
`endif

    step(nop, 1'b1);
    @(posedge Clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
